// File: rtl/param_reg_slave_if.sv
// Command bus between a master and the parametrised register-bank slave.
interface param_reg_slave_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              sready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output valid, we, addr, wdata,
    input  sready, rdata, rvalid, err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output sready, rdata, rvalid, err
  );
endinterface

// File: rtl/param_reg_slave.sv
// Parametrised register-bank slave with a registered command stage,
// programmable wait states on one address, read-back and range errors.
module param_reg_slave #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WAIT_ADDR   = 3,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  param_reg_slave_if.slave             bus,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

  localparam int unsigned CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit          WAIT_EN = (WAIT_CYCLES != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  cmd_t              cmd;
  logic              pend;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_sel_c;
  logic              accept_c;
  logic              commit_c;
  logic              wait_hit_c;
  logic              in_range_c;

  assign accept_c   = bus.valid && bus.sready;
  assign commit_c   = pend && (state == S_IDLE);
  assign wait_hit_c = WAIT_EN && (bus.addr == ADDR_W'(WAIT_ADDR));
  assign in_range_c = {1'b0, cmd.addr} < (ADDR_W + 1)'(NUM_REGS);

  // Next-state and wait counter: a WAIT_ADDR acceptance stalls the port for WAIT_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept_c && wait_hit_c) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; sready is registered from the next state so it is low only in WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bus.sready <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus.sready <= (state_nxt == S_IDLE);
    end
  end

  // Command stage: latched on acceptance, released on commit unless refilled at the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd  <= '0;
      pend <= 1'b0;
    end else if (accept_c) begin
      cmd.we    <= bus.we;
      cmd.addr  <= bus.addr;
      cmd.wdata <= bus.wdata;
      pend      <= 1'b1;
    end else if (commit_c) begin
      pend <= 1'b0;
    end
  end

  // Read mux over implemented registers; out-of-range addresses read as zero.
  always_comb begin
    rd_sel_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd.addr == ADDR_W'(i)) rd_sel_c = regs[i];
    end
  end

  // Commit: register write or read-back, plus one-cycle rvalid/err pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      if (commit_c) begin
        bus.err <= !in_range_c;
        if (cmd.we) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd.addr == ADDR_W'(i)) regs[i] <= cmd.wdata;
          end
        end else begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= rd_sel_c;
        end
      end
    end
  end

  // Flat view of the register bank straight from the flops.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_param_reg_slave.sv
// Scoreboard bench for param_reg_slave (NUM_REGS=4, WAIT_ADDR=3, WAIT_CYCLES=2).
module tb_param_reg_slave;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned NUM_REGS    = 4;
  localparam int unsigned WAIT_ADDR   = 3;
  localparam int unsigned WAIT_CYCLES = 2;

  typedef struct {
    logic              rd;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [DATA_W-1:0]          mdl [NUM_REGS];
  logic [DATA_W-1:0]          last_rd = '0;
  exp_t                       sb [$];
  int                         n_chk = 0;
  int                         n_err = 0;
  int                         low_cnt = 0;

  always #5 clk = ~clk;

  param_reg_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  param_reg_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .WAIT_ADDR(WAIT_ADDR), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bif.slave),
    .regs_flat(regs_flat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] mdl_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = mdl[i];
    return f;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one command until accepted; record model effects and expected responses.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic acc;
    int   n;
    exp_t e;
    acc = 1'b0;
    n   = 0;
    bif.valid = 1'b1;
    bif.we    = w;
    bif.addr  = a;
    bif.wdata = d;
    do begin
      @(negedge clk);
      acc = bif.sready && rstn;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else if (w) begin
      if (a < NUM_REGS) mdl[a] = d;
      else begin
        e.rd = 1'b0; e.data = '0; e.err = 1'b1;
        sb.push_back(e);
      end
    end else begin
      e.rd   = 1'b1;
      e.err  = (a >= NUM_REGS);
      e.data = (a < NUM_REGS) ? mdl[a] : '0;
      sb.push_back(e);
    end
    bif.valid = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every rvalid/err pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!bif.sready) low_cnt++;
    if (bif.rvalid || bif.err) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", {62'd0, bif.rvalid, bif.err}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rvalid", 64'(bif.rvalid), 64'(e.rd));
        chk("resp_err", 64'(bif.err), 64'(e.err));
        if (e.rd) begin
          chk("resp_rdata", 64'(bif.rdata), 64'(e.data));
          last_rd = e.data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    rstn      = 1'b0;
    bif.valid = 1'b0;
    bif.we    = 1'b0;
    bif.addr  = '0;
    bif.wdata = '0;
    mdl_clear();

    // Reset then idle
    tick(3);
    chk("rst_regs", 64'(regs_flat), 64'd0);
    chk("rst_sready", 64'(bif.sready), 64'd1);
    chk("rst_rvalid", 64'(bif.rvalid), 64'd0);
    chk("rst_err", 64'(bif.err), 64'd0);
    rstn = 1'b1;
    tick(5);
    chk("idle_regs", 64'(regs_flat), 64'd0);
    chk("idle_sready", 64'(bif.sready), 64'd1);
    chk("idle_rdata", 64'(bif.rdata), 64'd0);

    // Back-to-back writes
    base = low_cnt;
    issue(1'b1, 4'd0, 8'hA5);
    issue(1'b1, 4'd1, 8'h3C);
    issue(1'b1, 4'd2, 8'h01);
    tick(1);
    chk("b2b_regs", 64'(regs_flat[23:0]), 64'h013CA5);
    chk("b2b_sready_low", 64'(low_cnt - base), 64'd0);

    // Wait address: two stall cycles, commit at T+3
    base = low_cnt;
    issue(1'b1, 4'd3, 8'h0F);
    tick(2);
    chk("wait_not_yet", 64'(regs_flat[31:24]), 64'h00);
    tick(1);
    chk("wait_commit", 64'(regs_flat[31:24]), 64'h0F);
    chk("wait_low_cycles", 64'(low_cnt - base), 64'd2);
    issue(1'b0, 4'd3, 8'h00);
    tick(5);
    chk("wait_drain", 64'(sb.size()), 64'd0);

    // Read-after-write in consecutive cycles
    issue(1'b1, 4'd1, 8'h77);
    issue(1'b0, 4'd1, 8'h00);
    tick(4);
    chk("raw_drain", 64'(sb.size()), 64'd0);
    chk("rdata_hold", 64'(bif.rdata), 64'(last_rd));

    // Out of range write and read
    issue(1'b1, 4'd9, 8'hFF);
    tick(3);
    chk("oor_regs", 64'(regs_flat), 64'(mdl_flat()));
    issue(1'b0, 4'd9, 8'h00);
    tick(3);
    chk("oor_drain", 64'(sb.size()), 64'd0);
    chk("oor_rdata", 64'(bif.rdata), 64'd0);

    // Reset during the wait window discards the pending write
    issue(1'b1, 4'd3, 8'h55);
    @(negedge clk);
    rstn = 1'b0;
    mdl_clear();
    tick(2);
    chk("rstw_regs", 64'(regs_flat), 64'd0);
    chk("rstw_sready", 64'(bif.sready), 64'd1);
    rstn = 1'b1;
    tick(4);
    chk("rstw_after_regs", 64'(regs_flat), 64'd0);
    chk("rstw_after_sready", 64'(bif.sready), 64'd1);
    chk("rstw_no_resp", 64'(sb.size()), 64'd0);

    // Mixed random traffic across in-range, wait and out-of-range addresses
    for (int i = 0; i < 32; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ADDR_W'($urandom_range(0, 5));
      d = DATA_W'($urandom);
      issue(w, a, d);
      if ($urandom_range(0, 2) == 0) tick(1);
    end
    tick(6);
    chk("rand_regs", 64'(regs_flat), 64'(mdl_flat()));
    chk("rand_drain", 64'(sb.size()), 64'd0);
    chk("rand_rdata_hold", 64'(bif.rdata), 64'(last_rd));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
